mul_issue_ctrl: RTL
===================

// Module: mul_issue_ctrl
// PURPOSE
//  Front-end sequencer between the EX stage and the 4-pass multicycle multiplier
//  for RV32M MUL/MULH/MULHSU/MULHU. Accepts one request at a time over a valid/ready
//  handshake and converts the operands to unsigned magnitudes. It fires a one-cycle
//  calc pulse, captures product on done, sign-corrects it and selects the low or
//  high word. It holds the result until EX accepts it, and drains safely on pipeline flush.
// PARAMETERS
//  XLEN         32  operand width; must stay 32 (multiplier is fixed 32x32->64)
//  ZERO_BYPASS  1   1: a zero operand skips the multiplier; result 0 next cycle
//  DONE_TIMEOUT 15  max cycles in WAIT/DRAIN before err is raised
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   EX presents a multiply
//  req_ready    out  1   block can accept (IDLE only)
//  mul_op       in   2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  rs1, rs2     in   32  operands (rs1 = multiplicand)
//  resp_valid   out  1   resp_data valid
//  resp_ready   in   1   EX consumes result
//  resp_data    out  32  rd write value
//  flush        in   1   kill in-flight op (branch/exception)
//  busy         out  1   state != IDLE (stall source for hazard unit)
//  err          out  1   sticky: multiplier timeout
//  mult_a       out  32  magnitude |rs1| to multiplier a
//  mult_b       out  32  magnitude |rs2| to multiplier b
//  mult_calc    out  1   one-cycle start pulse to multiplier
//  mult_product in   64  multiplier product (valid only while mult_done)
//  mult_done    in   1   multiplier done strobe
// BEHAVIOUR
//  Reset (async): state=IDLE, all outputs 0 except req_ready=1, err cleared.
//  - rst must span >=1 rising edge so the sync-reset multiplier also returns to idle.
//  States: IDLE, ISSUE, WAIT, RESP, DRAIN.
//  - IDLE: req_ready=1. On req_valid & !flush, register op, the two neg flags and both
//    magnitudes. If ZERO_BYPASS and (rs1==0 | rs2==0): result=0 -> RESP. Else -> ISSUE.
//  - ISSUE: mult_calc=1 for exactly this cycle, mult_a/b = registered magnitudes
//    (held stable in all states after). -> WAIT. flush here -> DRAIN.
//  - WAIT: on mult_done, register the corrected result -> RESP. flush -> DRAIN.
//    flush & mult_done in the same cycle -> IDLE, result discarded.
//  - RESP: resp_valid=1; resp_data stable until resp_ready. resp_ready -> IDLE.
//    flush -> IDLE with no handshake (flush wins over resp_ready).
//  - DRAIN: wait for mult_done, discard, -> IDLE. Never re-issues calc while the
//    multiplier is busy.
//  - flush in IDLE with req_valid: request dropped.
//  Sign rules: neg_a = rs1[31] & (op==MULH|MULHSU); neg_b = rs2[31] & (op==MULH).
//  - |x| = neg ? -x : x (mod 2^32; 0x80000000 -> 0x80000000).
//  - p = (neg_a ^ neg_b) ? -mult_product : mult_product (64-bit two's complement).
//  - resp_data = (op==MUL) ? p[31:0] : p[63:32].
//  Latency (accept at cycle T): calc at T+1, mult_done at T+6, resp_valid at T+7.
//  - Zero bypass: resp_valid at T+1. Throughput: 1 op per 8 cycles, back-to-back.
//  Timeout: a counter runs in WAIT/DRAIN. At DONE_TIMEOUT cycles, err<=1 and state->IDLE.
//  busy = (state != IDLE); req_ready = (state == IDLE).
// TESTING
//  MUL 7 x 0xFFFFFFFD -> calc at T+1 only, resp_data 0xFFFFFFEB at T+7.
//  MULH/MULHU 0x80000000 x 0x80000000 -> 0x40000000 both.
//  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  rs1=0, rs2=0x1234 (MULH) -> resp_valid at T+1 with 0, mult_calc never asserted.
//  resp_ready held low 4 cycles in RESP -> resp_data constant, req_ready=0, then IDLE.
//  flush at T+3 -> no resp_valid, busy until cycle after mult_done (T+7).
//  - A following MUL 3x5 then returns 15.
//  Tie mult_done=0 -> err=1 at T+1+DONE_TIMEOUT, state IDLE. Async rst mid-WAIT -> outputs
//  clear without a clock edge.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// Issue sequencer for the 4-pass 32x32->64 multiplier: sign handling, calc pulse,
// result capture, response hold and flush draining for RV32M MUL/MULH/MULHSU/MULHU.
module mul_issue_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter bit          ZERO_BYPASS  = 1'b1,
    parameter int unsigned DONE_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        mul_op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    input  logic              flush,
    output logic              busy,
    output logic              err,
    output logic [XLEN-1:0]   mult_a,
    output logic [XLEN-1:0]   mult_b,
    output logic              mult_calc,
    input  logic [2*XLEN-1:0] mult_product,
    input  logic              mult_done
);

    localparam logic [1:0] OpMul    = 2'b00;
    localparam logic [1:0] OpMulh   = 2'b01;
    localparam logic [1:0] OpMulhsu = 2'b10;

    localparam int unsigned   CntW    = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DONE_TIMEOUT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StDrain} state_e;

    state_e          state_q;
    logic [1:0]      op_q;
    logic            neg_a_q;
    logic            neg_b_q;
    logic [CntW-1:0] cnt_q;

    logic              neg_a_in;
    logic              neg_b_in;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;
    logic              zero_in;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   res_sel;

    always_comb begin
        neg_a_in = rs1[XLEN-1] & ((mul_op == OpMulh) | (mul_op == OpMulhsu));
        neg_b_in = rs2[XLEN-1] & (mul_op == OpMulh);
        mag_a_in = neg_a_in ? -rs1 : rs1;
        mag_b_in = neg_b_in ? -rs2 : rs2;
        zero_in  = (rs1 == '0) | (rs2 == '0);
        // Multiplier works on magnitudes; restore the sign on the full 64-bit product.
        prod_fix = (neg_a_q ^ neg_b_q) ? -mult_product : mult_product;
        res_sel  = (op_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    assign busy       = (state_q != StIdle);
    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= OpMul;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            cnt_q     <= '0;
            resp_data <= '0;
            err       <= 1'b0;
            mult_a    <= '0;
            mult_b    <= '0;
            mult_calc <= 1'b0;
        end else begin
            mult_calc <= 1'b0;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (req_valid && !flush) begin
                        op_q    <= mul_op;
                        neg_a_q <= neg_a_in;
                        neg_b_q <= neg_b_in;
                        mult_a  <= mag_a_in;
                        mult_b  <= mag_b_in;
                        if (ZERO_BYPASS && zero_in) begin
                            resp_data <= '0;
                            state_q   <= StResp;
                        end else begin
                            mult_calc <= 1'b1;
                            state_q   <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    cnt_q   <= cnt_q + CntOne;
                    state_q <= flush ? StDrain : StWait;
                end
                StWait: begin
                    if (mult_done) begin
                        if (flush) begin
                            state_q <= StIdle;
                        end else begin
                            resp_data <= res_sel;
                            state_q   <= StResp;
                        end
                    end else if (flush) begin
                        cnt_q   <= cnt_q + CntOne;
                        state_q <= StDrain;
                    end else if (cnt_q == CntLast) begin
                        err     <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StResp: begin
                    if (flush || resp_ready) begin
                        state_q <= StIdle;
                    end
                end
                StDrain: begin
                    // The multiplier is still running; wait it out rather than re-issue.
                    if (mult_done) begin
                        state_q <= StIdle;
                    end else if (cnt_q == CntLast) begin
                        err     <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
